// File: rtl/rgb_to_luma_pkg.sv
// Shared constants, FSM state and control bundle
// for the RGB to luma front end.
package rgb_to_luma_pkg;

  localparam int COEF_R = 77;
  localparam int COEF_G = 150;
  localparam int COEF_B = 29;
  localparam int ROUND  = 128;

  localparam int COL_W = 11;
  localparam int ROW_W = 10;

  typedef enum logic {
    SYNC_WAIT,
    ACTIVE
  } state_t;

  typedef struct packed {
    logic             dv;
    logic             hs;
    logic             vs;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
  } ctrl_t;

endpackage

// File: rtl/rgb_to_luma_ctrl_delay.sv
// N-deep shift register that keeps dv/hs/vs and
// pixel position aligned with the luma pipeline.
module ctrl_delay
  import rgb_to_luma_pkg::*;
#(
  parameter int N = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  ctrl_t d,
  output ctrl_t q
);

  ctrl_t sr [N];

  // shift the control bundle one stage per clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++)
        sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/rgb_to_luma.sv
// BT.601 RGB to 8-bit luma, 3-stage pipeline with geometry checks.
// Optional macro RGB_TO_LUMA_TEST_PATTERN_EN adds a col^row pattern.
module rgb_to_luma
  import rgb_to_luma_pkg::*;
#(
  parameter int MAX_COLS = 1600,
  parameter int MAX_ROWS = 900,
  parameter int LATENCY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       r_i,
  input  logic [7:0]       g_i,
  input  logic [7:0]       b_i,
  input  logic             dv_i,
  input  logic             hs_i,
  input  logic             vs_i,
`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
  input  logic             pattern_en_i,
`endif
  output logic [7:0]       y_o,
  output logic             dv_o,
  output logic             hs_o,
  output logic             vs_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             line_err_o,
  output logic             frame_err_o
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("rgb_to_luma: LATENCY must be 3");
  end

  state_t           state, state_nxt;
  logic             hs_q, vs_q;
  logic             hs_rise, vs_rise;
  logic [COL_W-1:0] col, col_base, col_nxt;
  logic [ROW_W-1:0] row, row_base;
  logic             line_chk;
  logic             line_err_nxt;
  logic             frame_err_nxt;
  logic             active;

  assign hs_rise = hs_i & ~hs_q;
  assign vs_rise = vs_i & ~vs_q;
  assign active  = (state == ACTIVE);

  // state register plus input-side counters and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC_WAIT;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      hs_q        <= hs_i;
      vs_q        <= vs_i;
      col         <= col_nxt;
      row         <= row_base;
      line_err_o  <= line_err_nxt;
      frame_err_o <= frame_err_nxt;
    end
  end

  // next state, counter update and geometry checks
  always_comb begin
    state_nxt     = state;
    col_base      = col;
    row_base      = row;
    col_nxt       = col;
    line_chk      = 1'b0;
    line_err_nxt  = line_err_o;
    frame_err_nxt = frame_err_o;

    if (state == SYNC_WAIT && vs_rise)
      state_nxt = ACTIVE;

    // a line with no pixels is blanking, not a short line
    line_chk = hs_rise && (col != '0) &&
               (col != COL_W'(MAX_COLS));

    if (vs_rise) begin
      col_base = '0;
      row_base = '0;
    end else if (hs_rise) begin
      col_base = '0;
      if (col != '0 && row != '1)
        row_base = row + 1'b1;
    end

    col_nxt = col_base;
    if (dv_i && active && col_base != '1)
      col_nxt = col_base + 1'b1;

    // vs restarts both flags for the new frame
    if (vs_rise && active) begin
      line_err_nxt  = line_chk;
      frame_err_nxt = (row != ROW_W'(MAX_ROWS));
    end else begin
      line_err_nxt  = line_err_o | line_chk;
    end
  end

  ctrl_t ctrl_d, ctrl_q;

  assign ctrl_d.dv  = dv_i & active;
  assign ctrl_d.hs  = hs_i;
  assign ctrl_d.vs  = vs_i;
  assign ctrl_d.col = col_base;
  assign ctrl_d.row = row_base;

  ctrl_delay #(
    .N (LATENCY)
  ) u_ctrl_delay (
    .clk (clk),
    .rst (rst),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  assign dv_o  = ctrl_q.dv;
  assign hs_o  = ctrl_q.hs;
  assign vs_o  = ctrl_q.vs;
  assign col_o = ctrl_q.col;
  assign row_o = ctrl_q.row;

  logic [15:0] p_r, p_g, p_b;
  logic [16:0] s;
  logic        unused_s;

  // weights sum to 256, so s[16] never sets
  assign unused_s = ^{s[16], s[7:0]};

`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
  logic [7:0] pat1, pat2;

  // position pattern travels beside the luma data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat1 <= '0;
      pat2 <= '0;
    end else begin
      pat1 <= col_base[7:0] ^ row_base[7:0];
      pat2 <= pat1;
    end
  end
`endif

  // three-stage multiply, sum, truncate pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r <= '0;
      p_g <= '0;
      p_b <= '0;
      s   <= '0;
      y_o <= '0;
    end else begin
      p_r <= 16'(COEF_R) * {8'd0, r_i};
      p_g <= 16'(COEF_G) * {8'd0, g_i};
      p_b <= 16'(COEF_B) * {8'd0, b_i};
      s   <= {1'b0, p_r} + {1'b0, p_g} +
             {1'b0, p_b} + 17'(ROUND);
`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
      y_o <= pattern_en_i ? pat2 : s[15:8];
`else
      y_o <= s[15:8];
`endif
    end
  end

endmodule

// File: tb/tb_rgb_to_luma.sv
// Directed self-checking bench for rgb_to_luma
// using a reduced 8x4 frame geometry.
module tb_rgb_to_luma;

  localparam int MC = 8;
  localparam int MR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
  logic        dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [7:0]  y_o;
  logic        dv_o, hs_o, vs_o;
  logic [10:0] col_o;
  logic [9:0]  row_o;
  logic        line_err_o, frame_err_o;
`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
  logic        pattern_en_i = 1'b0;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rgb_to_luma #(
    .MAX_COLS (MC),
    .MAX_ROWS (MR),
    .LATENCY  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .r_i         (r_i),
    .g_i         (g_i),
    .b_i         (b_i),
    .dv_i        (dv_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
    .pattern_en_i(pattern_en_i),
`endif
    .y_o         (y_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .line_err_o  (line_err_o),
    .frame_err_o (frame_err_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b, input logic dv,
                       input logic hs, input logic vs);
    r_i = r; g_i = g; b_i = b;
    dv_i = dv; hs_i = hs; vs_i = vs;
    step();
  endtask

  task automatic vs_pulse();
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic line(input int n);
    for (int c = 0; c < n; c++)
      drive(8'd40, 8'd40, 8'd40, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if ({y_o, dv_o, hs_o, vs_o, col_o, row_o, line_err_o, frame_err_o} !== 34'd0)
      $display("FAIL reset_outputs: got y=%0d dv=%b col=%0d row=%0d le=%b fe=%b, want all 0",
               y_o, dv_o, col_o, row_o, line_err_o, frame_err_o);
    else passed++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 0, 0);
      checks++;
      if ({dv_o, y_o, line_err_o, frame_err_o} !== 11'd0)
        $display("FAIL sync_wait_%0d: dv=%b y=%0d le=%b fe=%b, want 0", i,
                 dv_o, y_o, line_err_o, frame_err_o);
      else passed++;
    end
  endtask

  task automatic test_luma();
    vs_pulse();
    drive(255, 255, 255, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(100, 50, 200, 1, 0, 0);
    checks++;
    if (y_o !== 8'd255 || dv_o !== 1'b1 || col_o !== 11'd0 || row_o !== 10'd0)
      $display("FAIL luma_white: y=%0d dv=%b col=%0d row=%0d, want 255 1 0 0",
               y_o, dv_o, col_o, row_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (y_o !== 8'd0 || dv_o !== 1'b1 || col_o !== 11'd1)
      $display("FAIL luma_black: y=%0d dv=%b col=%0d, want 0 1 1", y_o, dv_o, col_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (y_o !== 8'd82 || dv_o !== 1'b1 || col_o !== 11'd2)
      $display("FAIL luma_mix: y=%0d dv=%b col=%0d, want 82 1 2", y_o, dv_o, col_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (dv_o !== 1'b0)
      $display("FAIL luma_dv_drop: dv=%b, want 0", dv_o);
    else passed++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    vs_pulse();
    fork
      begin
        for (int l = 0; l < MR; l++) begin
          for (int c = 0; c < MC; c++) begin
            logic [7:0] v;
            v = 8'(c * 16 + l);
            drive(v, v, v, 1, 0, 0);
          end
          drive(0, 0, 0, 0, 1, 0);
          drive(0, 0, 0, 0, 0, 0);
          drive(0, 0, 0, 0, 0, 0);
        end
        drive(0, 0, 0, 0, 0, 0);
        vs_pulse();
        drive(0, 0, 0, 0, 0, 0);
      end
      begin
        for (int l = 0; l < MR; l++) begin
          int k;
          k = 0;
          while (dv_o !== 1'b1 && k < 20) begin
            step();
            k++;
          end
          checks++;
          if (k >= 20)
            $display("FAIL frame_wait_line%0d: dv_o=%b, want 1 within 20 cycles", l, dv_o);
          else passed++;
          for (int c = 0; c < MC; c++) begin
            logic [7:0] v;
            v = 8'(c * 16 + l);
            checks++;
            if (dv_o !== 1'b1 || col_o !== 11'(c) || row_o !== 10'(l) || y_o !== v)
              $display("FAIL frame_pix_%0d_%0d: dv=%b col=%0d row=%0d y=%0d, want 1 %0d %0d %0d",
                       l, c, dv_o, col_o, row_o, y_o, c, l, v);
            else passed++;
            step();
          end
          checks++;
          if (hs_o !== 1'b1 || dv_o !== 1'b0)
            $display("FAIL frame_hs_align%0d: hs=%b dv=%b, want 1 0", l, hs_o, dv_o);
          else passed++;
        end
      end
    join
    checks++;
    if (line_err_o !== 1'b0 || frame_err_o !== 1'b0)
      $display("FAIL frame_ok_flags: le=%b fe=%b, want 0 0", line_err_o, frame_err_o);
    else passed++;
  endtask

  task automatic test_line_err();
    for (int c = 0; c < MC - 1; c++)
      drive(8'd40, 8'd40, 8'd40, 1, 0, 0);
    checks++;
    if (line_err_o !== 1'b0)
      $display("FAIL short_line_pre: le=%b, want 0", line_err_o);
    else passed++;
    drive(0, 0, 0, 0, 1, 0);
    checks++;
    if (line_err_o !== 1'b1)
      $display("FAIL short_line_set: le=%b, want 1", line_err_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
    for (int l = 1; l < MR; l++)
      line(MC);
    checks++;
    if (line_err_o !== 1'b1)
      $display("FAIL short_line_sticky: le=%b, want 1", line_err_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (line_err_o !== 1'b0 || frame_err_o !== 1'b0)
      $display("FAIL short_line_clear: le=%b fe=%b, want 0 0", line_err_o, frame_err_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_frame_err();
    for (int l = 0; l < MR - 1; l++)
      line(MC);
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (frame_err_o !== 1'b1 || line_err_o !== 1'b0)
      $display("FAIL short_frame: fe=%b le=%b, want 1 0", frame_err_o, line_err_o);
    else passed++;
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++)
      drive(8'd90, 8'd90, 8'd90, 1, 0, 0);
    rst = 1'b1;
    #1;
    checks++;
    if ({y_o, dv_o, hs_o, vs_o, col_o, row_o, line_err_o, frame_err_o} !== 34'd0)
      $display("FAIL mid_reset: y=%0d dv=%b col=%0d row=%0d le=%b fe=%b, want all 0",
               y_o, dv_o, col_o, row_o, line_err_o, frame_err_o);
    else passed++;
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(8'd90, 8'd90, 8'd90, 1, 0, 0);
      checks++;
      if (dv_o !== 1'b0)
        $display("FAIL post_reset_dv_%0d: dv=%b, want 0", i, dv_o);
      else passed++;
    end
    drive(0, 0, 0, 0, 0, 1);
    drive(10, 10, 10, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (dv_o !== 1'b1 || y_o !== 8'd10 || col_o !== 11'd0 || row_o !== 10'd0)
      $display("FAIL resync: dv=%b y=%0d col=%0d row=%0d, want 1 10 0 0",
               dv_o, y_o, col_o, row_o);
    else passed++;
  endtask

`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
  task automatic test_pattern();
    vs_pulse();
    for (int l = 0; l < 3; l++)
      line(1);
    pattern_en_i = 1'b1;
    for (int c = 0; c < 6; c++)
      drive(8'd200, 8'd200, 8'd200, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (y_o !== 8'd6 || col_o !== 11'd5 || row_o !== 10'd3 || dv_o !== 1'b1)
      $display("FAIL pattern: y=%0d col=%0d row=%0d dv=%b, want 6 5 3 1",
               y_o, col_o, row_o, dv_o);
    else passed++;
    pattern_en_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_luma();
    do_reset();
    test_full_frame();
    test_line_err();
    test_frame_err();
`ifdef RGB_TO_LUMA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
